// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - write-back arbiter for the register-file write port with pending-write scoreboard (option macro: RF_WB_FIXED_PRIO_EN)
module rf_wb_arbiter #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_ready,
  input  logic            lsu_valid,
  input  logic [4:0]      lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  output logic            lsu_ready,
  input  logic            issue_valid,
  input  logic [4:0]      issue_rd,
  input  logic [4:0]      issue_rs1,
  input  logic [4:0]      issue_rs2,
  output logic            hazard_stall,
  output logic [NREG-1:0] pending,
  output logic            rf_we,
  output logic [4:0]      rf_rd_addr,
  output logic [XLEN-1:0] rf_rd_data
);

  logic            alu_grant;
  logic            lsu_grant;
  logic [NREG-1:0] pending_q;
  logic [NREG-1:0] pending_set;
  logic [NREG-1:0] pending_clr;

`ifdef RF_WB_FIXED_PRIO_EN
  // Fixed priority: the load/store unit always wins a tie
  always_comb begin
    lsu_grant = lsu_valid;
    alu_grant = alu_valid & ~lsu_valid;
  end
`else
  logic last_lsu;

  // Round robin: on a tie, grant whoever did not win most recently
  always_comb begin
    alu_grant = alu_valid & (~lsu_valid | last_lsu);
    lsu_grant = lsu_valid & (~alu_valid | ~last_lsu);
  end

  // Last-grant pointer moves only when something is granted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_lsu <= 1'b1;
    end else if (alu_grant | lsu_grant) begin
      last_lsu <= lsu_grant;
    end
  end
`endif

  assign alu_ready = alu_grant;
  assign lsu_ready = lsu_grant;

  // Registered write stage; x0 results are consumed without a write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we      <= 1'b0;
      rf_rd_addr <= 5'd0;
      rf_rd_data <= '0;
    end else if (alu_grant) begin
      rf_we      <= (alu_rd != 5'd0);
      rf_rd_addr <= alu_rd;
      rf_rd_data <= alu_data;
    end else if (lsu_grant) begin
      rf_we      <= (lsu_rd != 5'd0);
      rf_rd_addr <= lsu_rd;
      rf_rd_data <= lsu_data;
    end else begin
      rf_we      <= 1'b0;
    end
  end

  // Decode scoreboard set/clear masks; bit 0 is never touched so x0 stays clean
  always_comb begin
    pending_set = '0;
    pending_clr = '0;
    for (int i = 1; i < NREG; i++) begin
      if (issue_valid && (issue_rd == 5'(i))) pending_set[i] = 1'b1;
      if (rf_we && (rf_rd_addr == 5'(i)))     pending_clr[i] = 1'b1;
    end
  end

  // Scoreboard update; applying the set after the clear lets a new issue win
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
    end else begin
      pending_q <= (pending_q & ~pending_clr) | pending_set;
    end
  end

  assign pending      = pending_q;
  assign hazard_stall = pending_q[issue_rs1] | pending_q[issue_rs2];

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - self-checking bench for rf_wb_arbiter with a behavioural model
module tb_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid, lsu_valid, issue_valid;
  logic [4:0]  alu_rd, lsu_rd, issue_rd, issue_rs1, issue_rs2;
  logic [31:0] alu_data, lsu_data;
  logic        alu_ready, lsu_ready, hazard_stall, rf_we;
  logic [31:0] pending;
  logic [4:0]  rf_rd_addr;
  logic [31:0] rf_rd_data;

  rf_wb_arbiter #(.XLEN(32), .NREG(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .hazard_stall(hazard_stall), .pending(pending),
    .rf_we(rf_we), .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Behavioural model state
  bit          m_last_lsu;
  bit          m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  bit          m_pend[32];
  bit          alu_stall, lsu_stall;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // 0 = nobody, 1 = ALU, 2 = LSU
  function automatic int winner(bit av, bit lv, bit last_lsu);
    if (av && lv) begin
`ifdef RF_WB_FIXED_PRIO_EN
      return 2;
`else
      return last_lsu ? 1 : 2;
`endif
    end
    if (av) return 1;
    if (lv) return 2;
    return 0;
  endfunction

  function automatic logic [31:0] m_pend_vec();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = m_pend[i];
    return v;
  endfunction

  task automatic model_reset();
    m_last_lsu = 1'b1;
    m_we       = 1'b0;
    m_addr     = 5'd0;
    m_data     = 32'd0;
    for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
    alu_stall  = 1'b0;
    lsu_stall  = 1'b0;
  endtask

  task automatic model_step();
    int w;
    if (!rst_n) begin
      model_reset();
      return;
    end
    w = winner(alu_valid, lsu_valid, m_last_lsu);
    alu_stall = alu_valid && (w != 1);
    lsu_stall = lsu_valid && (w != 2);
    if (m_we) m_pend[m_addr] = 1'b0;
    if (issue_valid && issue_rd != 5'd0) m_pend[issue_rd] = 1'b1;
    if (w == 1) begin
      m_we = (alu_rd != 5'd0); m_addr = alu_rd; m_data = alu_data; m_last_lsu = 1'b0;
    end else if (w == 2) begin
      m_we = (lsu_rd != 5'd0); m_addr = lsu_rd; m_data = lsu_data; m_last_lsu = 1'b1;
    end else begin
      m_we = 1'b0;
    end
  endtask

  task automatic next_edge();
    @(posedge clk);
    model_step();
    #1;
  endtask

  // Every cycle: DUT outputs against the model
  always @(negedge clk) begin
    if (chk_en) begin
      int w;
      w = rst_n ? winner(alu_valid, lsu_valid, m_last_lsu) : winner(alu_valid, lsu_valid, 1'b1);
      chk("alu_ready", 64'(alu_ready), 64'(w == 1));
      chk("lsu_ready", 64'(lsu_ready), 64'(w == 2));
      chk("rf_we", 64'(rf_we), 64'(m_we));
      chk("rf_rd_addr", 64'(rf_rd_addr), 64'(m_addr));
      chk("rf_rd_data", 64'(rf_rd_data), 64'(m_data));
      chk("pending", 64'(pending), 64'(m_pend_vec()));
      chk("hazard_stall", 64'(hazard_stall), 64'(m_pend[issue_rs1] | m_pend[issue_rs2]));
    end
  end

  task automatic idle_inputs();
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
    issue_valid = 0; issue_rd = 0; issue_rs1 = 0; issue_rs2 = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    idle_inputs();
    next_edge();
    next_edge();
    rst_n = 1'b1;
  endtask

  logic [31:0] saved_pend;

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    chk_en = 1'b1;
    next_edge();
    next_edge();
    rst_n = 1'b1;
    #1;
    chk("reset rf_we", 64'(rf_we), 64'd0);
    chk("reset rf_rd_addr", 64'(rf_rd_addr), 64'd0);
    chk("reset rf_rd_data", 64'(rf_rd_data), 64'd0);
    chk("reset pending", 64'(pending), 64'd0);

    // Single ALU write to x5
    alu_valid = 1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    #1 chk("t1 alu_ready", 64'(alu_ready), 64'd1);
    next_edge();
    alu_valid = 0;
    #1;
    chk("t1 rf_we", 64'(rf_we), 64'd1);
    chk("t1 rf_rd_addr", 64'(rf_rd_addr), 64'd5);
    chk("t1 rf_rd_data", 64'(rf_rd_data), 64'hDEADBEEF);
    next_edge();
    #1 chk("t1 rf_we low", 64'(rf_we), 64'd0);

    // Tie for four cycles straight from reset
    do_reset();
    for (int k = 0; k < 4; k++) begin
      alu_valid = 1; alu_rd = 5'd1; alu_data = 32'h100 + 32'(k);
      lsu_valid = 1; lsu_rd = 5'd2; lsu_data = 32'h200 + 32'(k);
      #1;
`ifdef RF_WB_FIXED_PRIO_EN
      chk("t2 alu_ready", 64'(alu_ready), 64'd0);
      chk("t2 lsu_ready", 64'(lsu_ready), 64'd1);
`else
      chk("t2 alu_ready", 64'(alu_ready), 64'(k % 2 == 0));
      chk("t2 lsu_ready", 64'(lsu_ready), 64'(k % 2 == 1));
`endif
      next_edge();
    end
    idle_inputs();
    next_edge();

    // LSU result to x0 is consumed without a write
    saved_pend = pending;
    lsu_valid = 1; lsu_rd = 5'd0; lsu_data = 32'h1234;
    #1 chk("t3 lsu_ready", 64'(lsu_ready), 64'd1);
    next_edge();
    lsu_valid = 0;
    #1;
    chk("t3 rf_we", 64'(rf_we), 64'd0);
    chk("t3 pending", 64'(pending), 64'(saved_pend));

    // RAW hazard on x7 resolved by an ALU write
    issue_valid = 1; issue_rd = 5'd7;
    next_edge();
    issue_valid = 0; issue_rs1 = 5'd7; issue_rs2 = 5'd0;
    alu_valid = 1; alu_rd = 5'd7; alu_data = 32'h77;
    #1 chk("t4 stall after issue", 64'(hazard_stall), 64'd1);
    next_edge();
    alu_valid = 0;
    #1;
    chk("t4 rf_we", 64'(rf_we), 64'd1);
    chk("t4 stall in write cycle", 64'(hazard_stall), 64'd1);
    next_edge();
    #1 chk("t4 stall cleared", 64'(hazard_stall), 64'd0);

    // Issue of x9 while x9 is being written keeps it pending
    alu_valid = 1; alu_rd = 5'd9; alu_data = 32'h99;
    next_edge();
    alu_valid = 0; issue_valid = 1; issue_rd = 5'd9;
    #1;
    chk("t5 rf_we", 64'(rf_we), 64'd1);
    chk("t5 rf_rd_addr", 64'(rf_rd_addr), 64'd9);
    next_edge();
    issue_valid = 0;
    #1 chk("t5 pending9", 64'(pending[9]), 64'd1);

    // Mid-cycle reset drops the in-flight write and the scoreboard
    issue_valid = 1; issue_rd = 5'd3;
    lsu_valid = 1; lsu_rd = 5'd4; lsu_data = 32'h44;
    next_edge();
    idle_inputs();
    #1 chk("t6 rf_we before reset", 64'(rf_we), 64'd1);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("t6 pending in reset", 64'(pending), 64'd0);
    chk("t6 rf_we in reset", 64'(rf_we), 64'd0);
    next_edge();
    rst_n = 1'b1;
    next_edge();
    #1;
    chk("t6 rf_we after release", 64'(rf_we), 64'd0);
    chk("t6 pending after release", 64'(pending), 64'd0);

    // Randomised traffic; stalled requesters hold their payload
    for (int c = 0; c < 1500; c++) begin
      if (!alu_stall) begin
        alu_valid = ($urandom_range(0, 2) != 0);
        alu_rd    = 5'($urandom_range(0, 7));
        alu_data  = $urandom;
      end
      if (!lsu_stall) begin
        lsu_valid = ($urandom_range(0, 2) != 0);
        lsu_rd    = 5'($urandom_range(0, 7));
        lsu_data  = $urandom;
      end
      issue_valid = ($urandom_range(0, 2) == 0);
      issue_rd    = 5'($urandom_range(0, 7));
      issue_rs1   = 5'($urandom_range(0, 7));
      issue_rs2   = 5'($urandom_range(0, 7));
      next_edge();
    end

    idle_inputs();
    next_edge();
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
